// File: rtl/wu_tdc_pkg.sv
// wu_tdc_pkg: shared constants and arming-FSM state type for the wave-union TDC encoder.
`default_nettype none

package wu_tdc_pkg;

  localparam int TAPS_DEF     = 56;
  localparam int FINE_W_DEF   = 6;
  localparam int COARSE_W_DEF = 16;
  localparam int DROP_W_DEF   = 8;
  localparam int GROUPS_DEF   = TAPS_DEF / 4;

  typedef enum logic [1:0] {
    ST_REARM = 2'd0,
    ST_ARMED = 2'd1,
    ST_BUSY  = 2'd2
  } arm_state_t;

endpackage

`default_nettype wire

// File: rtl/wu_popcount4.sv
// wu_popcount4: combinational popcount of one CARRY4 group (4 taps -> 0..4).
`default_nettype none

module wu_popcount4 (
  input  logic [3:0] bits,
  output logic [2:0] count
);

  assign count = {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};

endmodule

`default_nettype wire

// File: rtl/wu_tdc_encoder.sv
// wu_tdc_encoder: samples the delay line, detects tap-0 rising hits and encodes
// fine time as the number of taps that changed between consecutive samples.
`default_nettype none

module wu_tdc_encoder
  import wu_tdc_pkg::*;
#(
  parameter int TAPS     = TAPS_DEF,
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TAPS-1:0]     taps_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FINE_W-1:0]   out_fine,
  output logic [COARSE_W-1:0] out_coarse,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int GROUPS = TAPS / 4;

  logic [TAPS-1:0]     s1, s2, d;
  logic                live;
  arm_state_t          state;
  logic [COARSE_W-1:0] coarse_cnt, c1, c2;
  logic                v1, v2;
  logic [2:0]          pop [GROUPS];
  logic [2:0]          p2  [GROUPS];
  logic [FINE_W-1:0]   total;
  logic                det, load, drop;

  assign det  = (state == ST_ARMED) && s1[0] && !s2[0];
  assign load = v2 && (!out_valid || out_ready);
  assign drop = v2 && out_valid && !out_ready;

  for (genvar g = 0; g < GROUPS; g++) begin : g_pop
    wu_popcount4 u_pop (
      .bits  (d[4*g +: 4]),
      .count (pop[g])
    );
  end

  always_comb begin
    total = '0;
    for (int g = 0; g < GROUPS; g++) begin
      total = total + FINE_W'(p2[g]);
    end
  end

  // Sampling, coarse time and arming FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      live       <= 1'b0;
      coarse_cnt <= '0;
      state      <= ST_REARM;
      d          <= '0;
      c1         <= '0;
      v1         <= 1'b0;
    end else begin
      s1         <= taps_in;
      s2         <= s1;
      // s1 holds its reset zero for one cycle; REARM must not mistake that for a real low tap.
      live       <= 1'b1;
      coarse_cnt <= coarse_cnt + 1'b1;
      v1         <= det;
      if (det) begin
        d  <= s1 ^ s2;
        c1 <= coarse_cnt;
      end
      case (state)
        ST_REARM: if (live && !s1[0]) state <= ST_ARMED;
        ST_ARMED: if (det)            state <= ST_BUSY;
        ST_BUSY:  if (!s1[0])         state <= ST_ARMED;
        default:                      state <= ST_REARM;
      endcase
    end
  end

  // Group popcounts, then sum and output register with drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < GROUPS; g++) p2[g] <= '0;
      c2         <= '0;
      v2         <= 1'b0;
      out_valid  <= 1'b0;
      out_fine   <= '0;
      out_coarse <= '0;
      drop_cnt   <= '0;
    end else begin
      for (int g = 0; g < GROUPS; g++) p2[g] <= pop[g];
      c2 <= c1;
      v2 <= v1;
      if (load) begin
        out_valid  <= 1'b1;
        out_fine   <= total;
        out_coarse <= c2;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wu_tdc_encoder.sv
// tb_wu_tdc_encoder: directed vectors with hand-computed fine/coarse expectations.
`default_nettype none

module tb_wu_tdc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] taps_in;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_fine;
  logic [15:0] out_coarse;
  logic [7:0]  drop_cnt;

  logic [15:0] mcnt;
  logic [15:0] ec_a, ec_b;
  logic        seen;
  int          total = 0;
  int          bad   = 0;

  wu_tdc_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .taps_in    (taps_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fine   (out_fine),
    .out_coarse (out_coarse),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference coarse count: edges since reset release
  always @(posedge clk) begin
    if (rst) mcnt <= 16'd0;
    else     mcnt <= mcnt + 16'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic watch_idle(input int n);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (out_valid) seen = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; taps_in = '0; out_ready = 1'b1;
    tick(3);
    check("rst_valid",  {63'd0, out_valid}, 64'd0);
    check("rst_fine",   {58'd0, out_fine}, 64'd0);
    check("rst_coarse", {48'd0, out_coarse}, 64'd0);
    check("rst_drop",   {56'd0, drop_cnt}, 64'd0);

    // Idle for 20 cycles
    rst = 1'b0;
    watch_idle(20);
    check("idle_valid", {63'd0, seen}, 64'd0);
    check("idle_drop",  {56'd0, drop_cnt}, 64'd0);
    check("idle_coarse_cnt", {48'd0, dut.coarse_cnt}, 64'd20);

    // Clean thermometer, detected with coarse_cnt = 37
    tick(16);
    taps_in = 56'h0000000_00FFFFF;
    tick(3);
    check("therm_latency", {63'd0, out_valid}, 64'd0);
    tick(1);
    check("therm_valid",  {63'd0, out_valid}, 64'd1);
    check("therm_fine",   {58'd0, out_fine}, 64'd20);
    check("therm_coarse", {48'd0, out_coarse}, 64'd37);
    taps_in = '0;
    tick(3);

    // Bubble + wave union (13 changed taps), then a second hit two cycles later
    taps_in = 56'h00000_3C00003DF; ec_a = mcnt + 16'd1;
    tick(1); taps_in = '0;
    tick(1); taps_in = 56'hFF; ec_b = mcnt + 16'd1;
    tick(1); taps_in = '0;
    tick(1);
    check("bubble_valid",  {63'd0, out_valid}, 64'd1);
    check("bubble_fine",   {58'd0, out_fine}, 64'd13);
    check("bubble_coarse", {48'd0, out_coarse}, {48'd0, ec_a});
    tick(1);
    check("bubble_gap", {63'd0, out_valid}, 64'd0);
    tick(1);
    check("second_valid",  {63'd0, out_valid}, 64'd1);
    check("second_fine",   {58'd0, out_fine}, 64'd8);
    check("second_coarse", {48'd0, out_coarse}, {48'd0, ec_b});
    tick(3);

    // Tap 0 high across reset release must not fire
    rst = 1'b1; taps_in = 56'h1;
    tick(3);
    rst = 1'b0;
    watch_idle(10);
    check("rearm_quiet", {63'd0, seen}, 64'd0);
    taps_in = '0;
    tick(2);
    taps_in = 56'h1; ec_a = mcnt + 16'd1;
    tick(4);
    check("rearm_valid",  {63'd0, out_valid}, 64'd1);
    check("rearm_fine",   {58'd0, out_fine}, 64'd1);
    check("rearm_coarse", {48'd0, out_coarse}, {48'd0, ec_a});
    watch_idle(8);
    check("rearm_single", {63'd0, seen}, 64'd0);
    taps_in = '0;
    tick(3);

    // Backpressure: three hits, first held, two dropped
    out_ready = 1'b0;
    taps_in = 56'hF; ec_a = mcnt + 16'd1;
    tick(1); taps_in = '0;
    tick(1); taps_in = 56'h3;
    tick(1); taps_in = '0;
    tick(1); taps_in = 56'h7;
    tick(1); taps_in = '0;
    tick(3);
    check("bp_valid",  {63'd0, out_valid}, 64'd1);
    check("bp_fine",   {58'd0, out_fine}, 64'd4);
    check("bp_coarse", {48'd0, out_coarse}, {48'd0, ec_a});
    check("bp_drop2",  {56'd0, drop_cnt}, 64'd2);
    out_ready = 1'b1;
    tick(1);
    check("bp_accept", {63'd0, out_valid}, 64'd0);
    check("bp_drop_hold", {56'd0, drop_cnt}, 64'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      taps_in = 56'h1; tick(1);
      taps_in = '0;    tick(1);
    end
    tick(6);
    check("sat_drop",  {56'd0, drop_cnt}, 64'd255);
    check("sat_valid", {63'd0, out_valid}, 64'd1);
    check("sat_fine",  {58'd0, out_fine}, 64'd1);

    // Coarse wrap: hits detected at 0xFFFF and 0x0001
    rst = 1'b1; taps_in = '0; out_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 70000 && mcnt != 16'hFFFE; i++) tick(1);
    check("wrap_reach", {48'd0, mcnt}, 64'hFFFE);
    taps_in = 56'h1;
    tick(1); taps_in = '0;
    tick(1); taps_in = 56'h1;
    tick(1); taps_in = '0;
    tick(1);
    check("wrap_valid1",  {63'd0, out_valid}, 64'd1);
    check("wrap_coarse1", {48'd0, out_coarse}, 64'hFFFF);
    tick(2);
    check("wrap_valid2",  {63'd0, out_valid}, 64'd1);
    check("wrap_coarse2", {48'd0, out_coarse}, 64'h0001);
    check("wrap_drop",    {56'd0, drop_cnt}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
